// File: rtl/psg_dcfilt_pkg.sv
// -----------------------------------------------------------------------------
// psg_dcfilt_pkg
//   Shared definitions for the PSG output conditioning filter.
//   - state_t   : sequencer states (idle, DC removal, low-pass, output)
//   - lp_width  : width of the signed low-pass state for given DW / GAIN_SHL
//   - sat_ow    : signed clamp of a wide value into an OW-bit signed range
// -----------------------------------------------------------------------------
package psg_dcfilt_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DC   = 2'd1,
      S_LP   = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   // Low-pass state holds the sign-extended, gain-shifted high-pass sample
   // plus one bit of headroom.
   function automatic int unsigned lp_width(input int unsigned dw,
                                            input int unsigned gain_shl);
      return dw + 32'd2 + gain_shl;
   endfunction

   // Clamp v into [-2^(ow-1), 2^(ow-1)-1]; v is carried sign-extended in 64 bits.
   function automatic logic signed [63:0] sat_ow(input logic signed [63:0] v,
                                                 input int unsigned      ow);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (ow - 32'd1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 32'd1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/psg_dcfilt_sat.sv
// -----------------------------------------------------------------------------
// psg_dcfilt_sat
//   Combinational signed clamp from the LW-bit low-pass state to the OW-bit
//   signed output range.
//   Ports:
//     lp_i  : signed LW-bit input value
//     sat_o : signed OW-bit saturated value
// -----------------------------------------------------------------------------
module psg_dcfilt_sat
   import psg_dcfilt_pkg::*;
#(
   parameter int unsigned LW = 17,
   parameter int unsigned OW = 16
) (
   input  logic signed [LW-1:0] lp_i,
   output logic signed [OW-1:0] sat_o
);

   always_comb begin
      sat_o = OW'(sat_ow(64'(lp_i), OW));
   end

endmodule

// File: rtl/psg_dcfilt.sv
// -----------------------------------------------------------------------------
// psg_dcfilt
//   Output conditioning stage behind the PSG core. Each sample strobe latches
//   the unsigned sound word, removes its DC offset with a shift-based running
//   average, applies a left-shift gain and a one-pole low-pass, saturates and
//   presents a signed sample with a one-clock valid pulse.
//
//   Build option:
//     PSG_DCFILT_PRELOAD_EN : the first sample after reset preloads the DC
//                             tracker so no initial step reaches the output.
//
//   Ports:
//     rst_n      : asynchronous active-low reset
//     clk        : clock, rising edge
//     clk_en     : clock enable; all state advances only when high
//     sample     : new-sample strobe, qualified by clk_en
//     din        : unsigned DW-bit PSG sound word
//     dout       : signed OW-bit filtered sample
//     dout_valid : one-clock pulse when dout updates
//     overrun    : sticky, set when a strobe arrives while a sample is in flight
// -----------------------------------------------------------------------------
module psg_dcfilt
   import psg_dcfilt_pkg::*;
#(
   parameter int unsigned DW       = 10,
   parameter int unsigned OW       = 16,
   parameter int unsigned DCSHIFT  = 10,
   parameter int unsigned GAIN_SHL = 5,
   parameter int unsigned LPSHIFT  = 2
) (
   input  logic                 rst_n,
   input  logic                 clk,
   input  logic                 clk_en,
   input  logic                 sample,
   input  logic [DW-1:0]        din,
   output logic signed [OW-1:0] dout,
   output logic                 dout_valid,
   output logic                 overrun
);

   localparam int unsigned AW = DW + DCSHIFT;
   localparam int unsigned LW = lp_width(DW, GAIN_SHL);
   localparam int unsigned SW = DW + 1 + GAIN_SHL;

   state_t                state_q, state_d;
   logic [DW-1:0]         x_q, x_d;
   logic [AW-1:0]         acc_q, acc_d;
   logic signed [DW:0]    hp_q, hp_d;
   logic signed [LW-1:0]  lp_q, lp_d;
   logic                  first_q, first_d;
   logic signed [OW-1:0]  dout_q, dout_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;

   logic [DW-1:0]         avg;
   logic [AW-1:0]         acc_upd;
   logic signed [DW:0]    hp_new;
   logic signed [SW-1:0]  scaled;
   logic signed [LW:0]    lp_diff;
   logic signed [LW:0]    lp_step;
   logic signed [LW-1:0]  lp_next;
   logic signed [OW-1:0]  sat_val;

   // Datapath terms
   always_comb begin
      avg     = acc_q[AW-1:DCSHIFT];
      // acc never exceeds x<<DCSHIFT range, so modular AW-bit math is exact.
      acc_upd = acc_q + AW'(x_q) - AW'(avg);
      hp_new  = $signed({1'b0, x_q}) - $signed({1'b0, avg});
      scaled  = SW'(hp_q) <<< GAIN_SHL;
      // One extra bit so scaled - lp cannot overflow before the shift.
      lp_diff = (LW+1)'(scaled) - (LW+1)'(lp_q);
      lp_step = lp_diff >>> LPSHIFT;
      if (LPSHIFT == 0) begin
         lp_next = LW'(scaled);
      end else begin
         lp_next = lp_q + LW'(lp_step);
      end
   end

   psg_dcfilt_sat #(
      .LW (LW),
      .OW (OW)
   ) u_sat (
      .lp_i  (lp_q),
      .sat_o (sat_val)
   );

   // Sequencer: next state and register updates
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      acc_d   = acc_q;
      hp_d    = hp_q;
      lp_d    = lp_q;
      first_d = first_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      ovr_d   = ovr_q;

      if (clk_en) begin
         if (sample && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (sample) begin
                  x_d     = din;
                  state_d = S_DC;
               end
            end
            S_DC: begin
               hp_d    = hp_new;
               acc_d   = acc_upd;
               first_d = 1'b0;
`ifdef PSG_DCFILT_PRELOAD_EN
               if (first_q) begin
                  acc_d = AW'(x_q) << DCSHIFT;
                  hp_d  = '0;
               end
`endif
               state_d = S_LP;
            end
            S_LP: begin
               lp_d    = lp_next;
               state_d = S_OUT;
            end
            S_OUT: begin
               dout_d  = sat_val;
               valid_d = 1'b1;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         acc_q   <= '0;
         hp_q    <= '0;
         lp_q    <= '0;
         first_q <= 1'b1;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         acc_q   <= acc_d;
         hp_q    <= hp_d;
         lp_q    <= lp_d;
         first_q <= first_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_psg_dcfilt.sv
// -----------------------------------------------------------------------------
// tb_psg_dcfilt
//   Bench for psg_dcfilt. Instance A uses default parameters, instance B uses
//   GAIN_SHL=6 / LPSHIFT=0 for saturation. Both share all inputs; a per-sample
//   arithmetic model tracks the expected output of each.
// -----------------------------------------------------------------------------
module tb_psg_dcfilt;

   logic               clk;
   logic               rst_n;
   logic               clk_en;
   logic               sample;
   logic [9:0]         din;
   logic signed [15:0] dout_a, dout_b;
   logic               valid_a, valid_b;
   logic               ovr_a, ovr_b;

   int vectors;
   int miscompares;

   psg_dcfilt u_dut_a (
      .rst_n      (rst_n),
      .clk        (clk),
      .clk_en     (clk_en),
      .sample     (sample),
      .din        (din),
      .dout       (dout_a),
      .dout_valid (valid_a),
      .overrun    (ovr_a)
   );

   psg_dcfilt #(
      .GAIN_SHL (6),
      .LPSHIFT  (0)
   ) u_dut_b (
      .rst_n      (rst_n),
      .clk        (clk),
      .clk_en     (clk_en),
      .sample     (sample),
      .din        (din),
      .dout       (dout_b),
      .dout_valid (valid_b),
      .overrun    (ovr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
`ifdef PSG_DCFILT_PRELOAD_EN
   localparam bit PRELOAD = 1'b1;
`else
   localparam bit PRELOAD = 1'b0;
`endif
   int     m_gain [2] = '{5, 6};
   int     m_lps  [2] = '{2, 0};
   longint m_acc  [2];
   longint m_lp   [2];
   bit     m_first[2];

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_acc[k]   = 0;
         m_lp[k]    = 0;
         m_first[k] = 1'b1;
      end
   endfunction

   function automatic longint floor_div(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   // One accepted sample through the filter equations of instance k.
   function automatic longint model_step(input int k, input int x);
      longint avg, hp, scaled;
      avg = m_acc[k] / 1024;
      if (PRELOAD && m_first[k]) begin
         m_acc[k] = longint'(x) * 1024;
         hp       = 0;
      end else begin
         hp       = longint'(x) - avg;
         m_acc[k] = m_acc[k] + longint'(x) - avg;
      end
      m_first[k] = 1'b0;
      scaled = hp * (longint'(1) << m_gain[k]);
      if (m_lps[k] == 0) m_lp[k] = scaled;
      else m_lp[k] = m_lp[k] + floor_div(scaled - m_lp[k], longint'(1) << m_lps[k]);
      if (m_lp[k] > 32767) return 32767;
      if (m_lp[k] < -32768) return -32768;
      return m_lp[k];
   endfunction

   // ------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      clk_en = 1'b1;
      sample = 1'b0;
      din    = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      model_reset();
   endtask

   // Present one strobe from S_IDLE, then wait for dout_valid. lat counts
   // enabled edges after the strobe edge. rnd_en randomly gates clk_en.
   task automatic do_sample(input int x, input bit rnd_en,
                            output bit got, output int lat,
                            output longint da, output longint db,
                            output bit vb);
      bit en;
      int t;
      clk_en = 1'b1;
      sample = 1'b1;
      din    = 10'(x);
      tick();
      sample = 1'b0;
      lat = 0;
      t   = 0;
      while (!valid_a && (lat < 10) && (t < 100)) begin
         clk_en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         en     = clk_en;
         tick();
         if (en) lat++;
         t++;
      end
      clk_en = 1'b1;
      got = valid_a;
      vb  = valid_b;
      da  = dout_a;
      db  = dout_b;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n  = 1'b0;
      clk_en = 1'b1;
      sample = 1'b0;
      din    = '0;
      #3;
      vectors++;
      if (dout_a !== 16'sd0) begin
         miscompares++;
         $display("FAIL reset_dout got=%0d exp=0", dout_a);
      end
      vectors++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid got=%b/%b exp=0/0", valid_a, valid_b);
      end
      vectors++;
      if (ovr_a !== 1'b0 || ovr_b !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_overrun got=%b/%b exp=0/0", ovr_a, ovr_b);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      bit got, vb; int lat; longint da, db, ea, eb;
      do_reset();
      do_sample(512, 1'b0, got, lat, da, db, vb);
      ea = model_step(0, 512);
      eb = model_step(1, 512);
      vectors++;
      if (!got || lat != 3) begin
         miscompares++;
         $display("FAIL single_latency got_valid=%b lat=%0d exp lat=3", got, lat);
      end
      vectors++;
      if (da != ea) begin
         miscompares++;
         $display("FAIL single_dout got=%0d exp=%0d", da, ea);
      end
`ifndef PSG_DCFILT_PRELOAD_EN
      vectors++;
      if (da != 4096) begin
         miscompares++;
         $display("FAIL single_dout_4096 got=%0d exp=4096", da);
      end
`endif
      tick();
      vectors++;
      if (valid_a !== 1'b0) begin
         miscompares++;
         $display("FAIL single_pulse_width got=%b exp=0", valid_a);
      end
      // Second sample continues from the same tracker state.
      do_sample(544, 1'b0, got, lat, da, db, vb);
      ea = model_step(0, 544);
      eb = model_step(1, 544);
      vectors++;
      if (!got || da != ea) begin
         miscompares++;
         $display("FAIL second_dout got=%0d valid=%b exp=%0d", da, got, ea);
      end
`ifdef PSG_DCFILT_PRELOAD_EN
      vectors++;
      if (da != 256) begin
         miscompares++;
         $display("FAIL preload_second got=%0d exp=256", da);
      end
`endif
   endtask

   task automatic test_saturate();
      bit got, vb; int lat; longint da, db, ea, eb;
      do_reset();
      do_sample(1023, 1'b0, got, lat, da, db, vb);
      ea = model_step(0, 1023);
      eb = model_step(1, 1023);
      vectors++;
      if (!vb || db != eb) begin
         miscompares++;
         $display("FAIL sat_dout got=%0d valid=%b exp=%0d", db, vb, eb);
      end
`ifndef PSG_DCFILT_PRELOAD_EN
      vectors++;
      if (db != 32767) begin
         miscompares++;
         $display("FAIL sat_max got=%0d exp=32767", db);
      end
`endif
   endtask

   task automatic test_random();
      bit got, vb; int lat, x; longint da, db, ea, eb;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         x = $urandom_range(0, 1023);
         do_sample(x, 1'b1, got, lat, da, db, vb);
         ea = model_step(0, x);
         eb = model_step(1, x);
         vectors++;
         if (!got || !vb || da != ea || db != eb) begin
            miscompares++;
            $display("FAIL random[%0d] x=%0d got=%0d/%0d valid=%b/%b exp=%0d/%0d",
                     i, x, da, db, got, vb, ea, eb);
         end
         repeat ($urandom_range(0, 3)) tick();
      end
      vectors++;
      if (ovr_a !== 1'b0) begin
         miscompares++;
         $display("FAIL random_no_overrun got=%b exp=0", ovr_a);
      end
   endtask

   task automatic test_overrun();
      bit got, vb; int lat, t; longint da, db, ea, eb;
      do_reset();
      sample = 1'b1;
      din    = 10'd300;
      tick();               // accepted, now in S_DC
      sample = 1'b0;
      tick();               // now in S_LP
      sample = 1'b1;
      din    = 10'd99;
      tick();               // strobe while busy
      sample = 1'b0;
      ea = model_step(0, 300);
      eb = model_step(1, 300);
      t = 0;
      while (!valid_a && t < 10) begin
         tick();
         t++;
      end
      vectors++;
      if (ovr_a !== 1'b1) begin
         miscompares++;
         $display("FAIL overrun_set got=%b exp=1", ovr_a);
      end
      vectors++;
      if (!valid_a || dout_a != ea) begin
         miscompares++;
         $display("FAIL overrun_inflight got=%0d valid=%b exp=%0d", dout_a, valid_a, ea);
      end
      do_sample(100, 1'b0, got, lat, da, db, vb);
      ea = model_step(0, 100);
      eb = model_step(1, 100);
      vectors++;
      if (!got || da != ea || ovr_a !== 1'b1) begin
         miscompares++;
         $display("FAIL overrun_sticky got=%0d ovr=%b exp=%0d ovr=1", da, ovr_a, ea);
      end
      rst_n = 1'b0;
      #2;
      vectors++;
      if (ovr_a !== 1'b0) begin
         miscompares++;
         $display("FAIL overrun_clear got=%b exp=0", ovr_a);
      end
      tick();
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_clken_hold();
      int lat, t; longint ea, eb; bit en;
      do_reset();
      sample = 1'b1;
      din    = 10'd700;
      tick();               // now in S_DC
      clk_en = 1'b0;        // strobe held high while disabled
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (valid_a !== 1'b0 || dout_a !== 16'sd0) begin
            miscompares++;
            $display("FAIL hold[%0d] valid=%b dout=%0d exp 0/0", i, valid_a, dout_a);
         end
      end
      sample = 1'b0;
      vectors++;
      if (ovr_a !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_overrun got=%b exp=0", ovr_a);
      end
      ea = model_step(0, 700);
      eb = model_step(1, 700);
      lat = 0;
      t   = 0;
      while (!valid_a && t < 10) begin
         clk_en = 1'b1;
         en = clk_en;
         tick();
         if (en) lat++;
         t++;
      end
      vectors++;
      if (!valid_a || lat != 3 || dout_a != ea) begin
         miscompares++;
         $display("FAIL hold_resume valid=%b lat=%0d dout=%0d exp lat=3 dout=%0d",
                  valid_a, lat, dout_a, ea);
      end
   endtask

   task automatic test_reset_mid();
      bit got, vb, seen; int lat; longint da, db, ea, eb;
      do_reset();
      do_sample(400, 1'b0, got, lat, da, db, vb);
      ea = model_step(0, 400);
      eb = model_step(1, 400);
      sample = 1'b1;
      din    = 10'd512;
      tick();
      sample = 1'b0;
      tick();               // now in S_LP
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (dout_a !== 16'sd0 || valid_a !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset got dout=%0d valid=%b exp 0/0", dout_a, valid_a);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      model_reset();
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (valid_a) seen = 1'b1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL midreset_no_output got valid=1 exp=0");
      end
      do_sample(512, 1'b0, got, lat, da, db, vb);
      ea = model_step(0, 512);
      eb = model_step(1, 512);
      vectors++;
      if (!got || da != ea) begin
         miscompares++;
         $display("FAIL midreset_restart got=%0d valid=%b exp=%0d", da, got, ea);
      end
   endtask

   task automatic test_converge();
      bit got, vb, falling, mono_bad; int lat; longint da, db, ea, eb, prev;
      int bad;
      do_reset();
      falling  = 1'b0;
      mono_bad = 1'b0;
      prev     = 0;
      bad      = 0;
      for (int i = 0; i < 10000; i++) begin
         do_sample(512, 1'b0, got, lat, da, db, vb);
         ea = model_step(0, 512);
         eb = model_step(1, 512);
         vectors++;
         if (!got || da != ea) begin
            miscompares++;
            bad++;
            if (bad <= 5)
               $display("FAIL converge[%0d] got=%0d valid=%b exp=%0d", i, da, got, ea);
         end
         if (i > 0) begin
            if (da < prev) falling = 1'b1;
            else if (falling && da > prev) mono_bad = 1'b1;
         end
         prev = da;
      end
      vectors++;
      if (da > 64 || da < -64) begin
         miscompares++;
         $display("FAIL converge_final got=%0d exp |dout|<=64", da);
      end
      vectors++;
      if (mono_bad) begin
         miscompares++;
         $display("FAIL converge_monotonic got rising after decay exp non-increasing");
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n  = 1'b0;
      clk_en = 1'b0;
      sample = 1'b0;
      din    = '0;
      test_reset();
      test_single();
      test_saturate();
      test_overrun();
      test_clken_hold();
      test_reset_mid();
      test_random();
      test_converge();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
